// File: rtl/mem_arbiter_wb.sv
// -----------------------------------------------------------------------------
// mem_arbiter_wb
//
// Single-port RAM arbiter for one core. It sits between the i$ and d$ request
// ports and the RAM and holds d$ stores in a posted write buffer (circular
// FIFO) so that stores never stall the core while the RAM is busy. Loads are
// answered straight from the buffer when it holds the address (youngest store
// wins); otherwise they are read from RAM. RAM wait states are honoured
// through ramstate. halt_out reports a halt only once every posted store has
// reached RAM.
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   icache_REN/addr        i$ read request (byte address)
//   icache_hit/load        i$ data valid this cycle / data (= ramload)
//   dread_valid/lq/addr    d$ load request, load-queue tag, word address
//   dread_blocked          load not accepted this cycle (arbiter busy)
//   dresp_valid/lq/data    single-cycle load response
//   dwrite_valid/addr/data d$ store request (word address)
//   dwrite_blocked         store not accepted (write buffer full)
//   memaddr/memREN/memWEN  RAM request (byte address)
//   memstore               RAM write data (head of the write buffer)
//   ramstate, ramload      RAM handshake state and read data
//   halt_in, halt_out      core halted / halted with buffer drained
// -----------------------------------------------------------------------------
package mem_arbiter_wb_pkg;
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;
endpackage

module mem_arbiter_wb
   import mem_arbiter_wb_pkg::*;
#(
   parameter int WB_DEPTH = 4,
   parameter int ADDR_W   = 14,
   parameter int LQ_W     = 3
) (
   input  logic              CLK,
   input  logic              nRST,

   input  logic              icache_REN,
   input  logic [31:0]       icache_addr,
   output logic              icache_hit,
   output logic [31:0]       icache_load,

   input  logic              dread_valid,
   input  logic [LQ_W-1:0]   dread_lq,
   input  logic [ADDR_W-1:0] dread_addr,
   output logic              dread_blocked,
   output logic              dresp_valid,
   output logic [LQ_W-1:0]   dresp_lq,
   output logic [31:0]       dresp_data,

   input  logic              dwrite_valid,
   input  logic [ADDR_W-1:0] dwrite_addr,
   input  logic [31:0]       dwrite_data,
   output logic              dwrite_blocked,

   output logic [31:0]       memaddr,
   output logic              memREN,
   output logic              memWEN,
   output logic [31:0]       memstore,
   input  ramstate_t         ramstate,
   input  logic [31:0]       ramload,

   input  logic              halt_in,
   output logic              halt_out
);

   localparam int IDX_W = $clog2(WB_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, DREAD, WRITE, IREAD} state_t;

   state_t state, next_state;

   // Write buffer: pointers carry one extra wrap bit to tell full from empty.
   logic [PTR_W-1:0]  head, tail, head_nxt, tail_nxt;
   logic [IDX_W-1:0]  head_idx, tail_idx;
   logic [WB_DEPTH-1:0] wb_valid;
   logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
   logic [31:0]       wb_data [WB_DEPTH];
   logic              full_q;
   logic              full_nxt;
   logic              wb_empty;
   logic              head_valid;

   logic              ram_done;
   logic              enq, deq;
   logic              ld_accept;

   // Load forwarding CAM results.
   logic              fwd_hit;
   logic [31:0]       fwd_data;
   logic [IDX_W-1:0]  slot;

   // Captured RAM-load request.
   logic [ADDR_W-1:0] ld_addr_q;
   logic [LQ_W-1:0]   ld_lq_q;

   assign head_idx   = head[IDX_W-1:0];
   assign tail_idx   = tail[IDX_W-1:0];
   assign wb_empty   = (head == tail);
   assign head_valid = wb_valid[head_idx];

   // ERROR completes the access like ACCESS; the data is taken as-is.
   assign ram_done  = (ramstate == ACCESS) || (ramstate == ERROR);
   assign enq       = dwrite_valid & ~full_q;
   assign deq       = (state == WRITE) & ram_done;
   assign ld_accept = dread_valid & (state == IDLE);

   assign head_nxt = head + {{(PTR_W-1){1'b0}}, deq};
   assign tail_nxt = tail + {{(PTR_W-1){1'b0}}, enq};
   assign full_nxt = (head_nxt[IDX_W-1:0] == tail_nxt[IDX_W-1:0]) &&
                     (head_nxt[PTR_W-1] != tail_nxt[PTR_W-1]);

   assign dwrite_blocked = full_q;
   assign dread_blocked  = (state != IDLE);
   assign halt_out       = halt_in & wb_empty & (state == IDLE);
   assign icache_load    = ramload;
   assign memstore       = wb_data[head_idx];

   // Walk the buffer oldest to youngest from the head so the last match is the
   // youngest one; a store enqueuing this very cycle is younger still.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         slot = head_idx + IDX_W'(i);
         if (wb_valid[slot] && (wb_addr[slot] == dread_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data[slot];
         end
      end
      if (enq && (dwrite_addr == dread_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = dwrite_data;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         // NOTE: state and all other flops use non-blocking assignment so every
         // register samples pre-edge values regardless of process order.
         state <= next_state;
      end
   end

   // Next state and RAM request. Priority in IDLE: load, buffered store, i$.
   always_comb begin
      next_state = state;
      memREN     = 1'b0;
      memWEN     = 1'b0;
      memaddr    = '0;
      icache_hit = 1'b0;
      case (state)
         IDLE: begin
            if (dread_valid) begin
               next_state = fwd_hit ? IDLE : DREAD;
            end else if (head_valid) begin
               next_state = WRITE;
            end else if (icache_REN) begin
               next_state = IREAD;
            end
         end
         DREAD: begin
            memREN  = 1'b1;
            memaddr = 32'({ld_addr_q, 2'b00});
            if (ram_done) next_state = IDLE;
         end
         WRITE: begin
            memWEN  = 1'b1;
            memaddr = 32'({wb_addr[head_idx], 2'b00});
            if (ram_done) next_state = IDLE;
         end
         IREAD: begin
            memREN     = 1'b1;
            memaddr    = icache_addr;
            icache_hit = ram_done;
            if (ram_done) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Buffer control: pointers, per-entry valid bits, registered full flag.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head     <= '0;
         tail     <= '0;
         wb_valid <= '0;
         full_q   <= 1'b0;
      end else begin
         // Enqueue and dequeue never hit the same slot: that would need the
         // buffer full, and a full buffer refuses the enqueue.
         if (enq) wb_valid[tail_idx] <= 1'b1;
         if (deq) wb_valid[head_idx] <= 1'b0;
         head   <= head_nxt;
         tail   <= tail_nxt;
         full_q <= full_nxt;
      end
   end

   // NOTE: the entry payload has no reset; the valid bits alone decide whether
   // an entry is meaningful, so clearing the storage would only cost area.
   always_ff @(posedge CLK) begin
      if (enq) begin
         wb_addr[tail_idx] <= dwrite_addr;
         wb_data[tail_idx] <= dwrite_data;
      end
   end

   // Load request capture and single-cycle response.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ld_addr_q   <= '0;
         ld_lq_q     <= '0;
         dresp_valid <= 1'b0;
         dresp_lq    <= '0;
         dresp_data  <= '0;
      end else begin
         dresp_valid <= 1'b0;
         if (ld_accept && !fwd_hit) begin
            ld_addr_q <= dread_addr;
            ld_lq_q   <= dread_lq;
         end
         if (ld_accept && fwd_hit) begin
            dresp_valid <= 1'b1;
            dresp_lq    <= dread_lq;
            dresp_data  <= fwd_data;
         end else if ((state == DREAD) && ram_done) begin
            dresp_valid <= 1'b1;
            dresp_lq    <= ld_lq_q;
            dresp_data  <= ramload;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_wb
//
// Directed bench for mem_arbiter_wb. A transaction-level model (a queue of
// posted stores plus the RAM transaction in flight) predicts every output on
// every falling edge; directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_wb;
   import mem_arbiter_wb_pkg::*;

   localparam int WB_DEPTH = 4;
   localparam int ADDR_W   = 14;
   localparam int LQ_W     = 3;

   logic              CLK;
   logic              nRST;
   logic              icache_REN;
   logic [31:0]       icache_addr;
   logic              icache_hit;
   logic [31:0]       icache_load;
   logic              dread_valid;
   logic [LQ_W-1:0]   dread_lq;
   logic [ADDR_W-1:0] dread_addr;
   logic              dread_blocked;
   logic              dresp_valid;
   logic [LQ_W-1:0]   dresp_lq;
   logic [31:0]       dresp_data;
   logic              dwrite_valid;
   logic [ADDR_W-1:0] dwrite_addr;
   logic [31:0]       dwrite_data;
   logic              dwrite_blocked;
   logic [31:0]       memaddr;
   logic              memREN;
   logic              memWEN;
   logic [31:0]       memstore;
   ramstate_t         ramstate;
   logic [31:0]       ramload;
   logic              halt_in;
   logic              halt_out;

   mem_arbiter_wb #(.WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W), .LQ_W(LQ_W)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .icache_REN     (icache_REN),
      .icache_addr    (icache_addr),
      .icache_hit     (icache_hit),
      .icache_load    (icache_load),
      .dread_valid    (dread_valid),
      .dread_lq       (dread_lq),
      .dread_addr     (dread_addr),
      .dread_blocked  (dread_blocked),
      .dresp_valid    (dresp_valid),
      .dresp_lq       (dresp_lq),
      .dresp_data     (dresp_data),
      .dwrite_valid   (dwrite_valid),
      .dwrite_addr    (dwrite_addr),
      .dwrite_data    (dwrite_data),
      .dwrite_blocked (dwrite_blocked),
      .memaddr        (memaddr),
      .memREN         (memREN),
      .memWEN         (memWEN),
      .memstore       (memstore),
      .ramstate       (ramstate),
      .ramload        (ramload),
      .halt_in        (halt_in),
      .halt_out       (halt_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_b(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model --
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wb_ent_t;

   typedef enum {K_NONE, K_LOAD, K_STORE, K_FETCH} kind_t;

   wb_ent_t         wbq[$];        // posted stores, oldest first
   kind_t           m_kind = K_NONE;
   logic [31:0]     m_addr = '0;   // byte address of the RAM read in flight
   logic [LQ_W-1:0] m_tag  = '0;
   logic            m_resp_v    = 1'b0;
   logic [LQ_W-1:0] m_resp_lq   = '0;
   logic [31:0]     m_resp_data = '0;

   task automatic model_step();
      bit          acc, st_ok, hit;
      logic [31:0] d;
      int          n;
      acc   = (ramstate == ACCESS) || (ramstate == ERROR);
      n     = wbq.size();
      st_ok = dwrite_valid && (n < WB_DEPTH);
      m_resp_v = 1'b0;
      if (m_kind == K_NONE) begin
         if (dread_valid) begin
            hit = 0;
            d   = '0;
            foreach (wbq[i]) if (wbq[i].addr == dread_addr) begin hit = 1; d = wbq[i].data; end
            if (st_ok && (dwrite_addr == dread_addr)) begin hit = 1; d = dwrite_data; end
            if (hit) begin
               m_resp_v    = 1'b1;
               m_resp_lq   = dread_lq;
               m_resp_data = d;
            end else begin
               m_kind = K_LOAD;
               m_addr = 32'(dread_addr) * 4;
               m_tag  = dread_lq;
            end
         end else if (n > 0) begin
            m_kind = K_STORE;
         end else if (icache_REN) begin
            m_kind = K_FETCH;
            m_addr = icache_addr;
         end
      end else if (acc) begin
         if (m_kind == K_LOAD) begin
            m_resp_v    = 1'b1;
            m_resp_lq   = m_tag;
            m_resp_data = ramload;
         end
         if (m_kind == K_STORE) void'(wbq.pop_front());
         m_kind = K_NONE;
      end
      if (st_ok) wbq.push_back('{addr: dwrite_addr, data: dwrite_data});
   endtask

   initial begin
      forever begin
         @(posedge CLK or negedge nRST);
         if (!nRST) begin
            wbq.delete();
            m_kind      = K_NONE;
            m_resp_v    = 1'b0;
            m_resp_lq   = '0;
            m_resp_data = '0;
         end else begin
            model_step();
         end
      end
   end

   task automatic compare_outputs();
      bit          acc;
      logic [31:0] e_addr;
      acc    = (ramstate == ACCESS) || (ramstate == ERROR);
      e_addr = '0;
      if (m_kind == K_LOAD || m_kind == K_FETCH) e_addr = m_addr;
      else if (m_kind == K_STORE && wbq.size() > 0) e_addr = 32'(wbq[0].addr) * 4;
      check_b("mdl_memREN", memREN, (m_kind == K_LOAD) || (m_kind == K_FETCH));
      check_b("mdl_memWEN", memWEN, m_kind == K_STORE);
      check_w("mdl_memaddr", memaddr, e_addr);
      check_b("mdl_icache_hit", icache_hit, (m_kind == K_FETCH) && acc);
      check_w("mdl_icache_load", icache_load, ramload);
      check_b("mdl_dread_blocked", dread_blocked, m_kind != K_NONE);
      check_b("mdl_dwrite_blocked", dwrite_blocked, wbq.size() == WB_DEPTH);
      check_b("mdl_halt_out", halt_out, halt_in && (wbq.size() == 0) && (m_kind == K_NONE));
      check_b("mdl_dresp_valid", dresp_valid, m_resp_v);
      if (m_resp_v) begin
         check_w("mdl_dresp_lq", 32'(dresp_lq), 32'(m_resp_lq));
         check_w("mdl_dresp_data", dresp_data, m_resp_data);
      end
      if (m_kind == K_STORE && wbq.size() > 0) check_w("mdl_memstore", memstore, wbq[0].data);
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         compare_outputs();
      end
   end

   // Log of completed RAM writes (address, data) in the order they happen.
   wb_ent_t wr_log[$];
   logic [31:0] wr_log_addr[$];
   initial begin
      forever begin
         @(negedge CLK);
         if (nRST && memWEN && ((ramstate == ACCESS) || (ramstate == ERROR))) begin
            wr_log_addr.push_back(memaddr);
            wr_log.push_back('{addr: '0, data: memstore});
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------- stimulus --
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic neg();
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      icache_REN   = 1'b0;
      icache_addr  = '0;
      dread_valid  = 1'b0;
      dread_lq     = '0;
      dread_addr   = '0;
      dwrite_valid = 1'b0;
      dwrite_addr  = '0;
      dwrite_data  = '0;
      ramstate     = FREE;
      ramload      = '0;
      halt_in      = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_b({tag, "_memREN"}, memREN, 1'b0);
      check_b({tag, "_memWEN"}, memWEN, 1'b0);
      check_w({tag, "_memaddr"}, memaddr, 32'h0);
      check_b({tag, "_icache_hit"}, icache_hit, 1'b0);
      check_b({tag, "_dresp_valid"}, dresp_valid, 1'b0);
      check_w({tag, "_dresp_lq"}, 32'(dresp_lq), 32'h0);
      check_w({tag, "_dresp_data"}, dresp_data, 32'h0);
      check_b({tag, "_dwrite_blocked"}, dwrite_blocked, 1'b0);
      check_b({tag, "_halt_out"}, halt_out, 1'b0);
      check_b({tag, "_dread_blocked"}, dread_blocked, 1'b0);
   endtask

   initial begin
      nRST = 1'b0;
      idle_inputs();

      // ---- Reset in the middle of an i$ read held by BUSY
      repeat (2) cyc();
      nRST = 1'b1;
      icache_REN = 1'b1; icache_addr = 32'h0000_0100; ramstate = BUSY;
      cyc();
      neg();
      check_b("iread_memREN", memREN, 1'b1);
      check_w("iread_memaddr", memaddr, 32'h0000_0100);
      cyc();
      nRST = 1'b0;
      neg();
      check_all_zero("rst1");
      cyc();
      neg();
      check_all_zero("rst2");
      cyc();
      nRST = 1'b1; icache_REN = 1'b0; ramstate = FREE;
      neg();
      check_b("post_rst_memREN", memREN, 1'b0);
      check_b("post_rst_idle", dread_blocked, 1'b0);
      cyc();

      // ---- Forwarding: stores queue up behind a RAM load of 0x30
      dread_valid = 1'b1; dread_lq = 3'd1; dread_addr = 14'h30; ramstate = BUSY;
      cyc();
      dread_valid = 1'b0; dwrite_valid = 1'b1; dwrite_addr = 14'h10; dwrite_data = 32'hA;
      cyc();
      dwrite_data = 32'hB;
      cyc();
      dwrite_valid = 1'b0; ramstate = ACCESS; ramload = 32'h1111;
      neg();
      check_b("fwd_ld_blocked", dread_blocked, 1'b1);
      cyc();
      dread_valid = 1'b1; dread_lq = 3'd5; dread_addr = 14'h10; ramstate = BUSY; ramload = '0;
      neg();
      check_b("ram_ld_valid", dresp_valid, 1'b1);
      check_w("ram_ld_lq", 32'(dresp_lq), 32'd1);
      check_w("ram_ld_data", dresp_data, 32'h1111);
      check_b("fwd_no_memREN0", memREN, 1'b0);
      cyc();
      dread_lq = 3'd6; dwrite_valid = 1'b1; dwrite_addr = 14'h10; dwrite_data = 32'hC;
      neg();
      check_b("fwd_valid", dresp_valid, 1'b1);
      check_w("fwd_lq", 32'(dresp_lq), 32'd5);
      check_w("fwd_data", dresp_data, 32'hB);
      check_b("fwd_no_memREN1", memREN, 1'b0);
      cyc();
      dread_valid = 1'b0; dwrite_valid = 1'b0;
      neg();
      check_b("fwd_same_valid", dresp_valid, 1'b1);
      check_w("fwd_same_lq", 32'(dresp_lq), 32'd6);
      check_w("fwd_same_data", dresp_data, 32'hC);
      check_b("fwd_no_memREN2", memREN, 1'b0);
      cyc();
      neg();
      check_b("fwd_pulse", dresp_valid, 1'b0);
      check_b("drain_first_wen", memWEN, 1'b1);
      check_w("drain_first_addr", memaddr, 32'h0000_0040);
      check_w("drain_first_data", memstore, 32'hA);
      cyc();
      ramstate = ACCESS;
      repeat (8) cyc();
      ramstate = FREE;
      cyc();

      // ---- Fill with RAM busy, then drain in FIFO order
      ramstate = BUSY;
      for (int i = 0; i < 4; i++) begin
         dwrite_valid = 1'b1;
         dwrite_addr  = 14'(16 + i);
         dwrite_data  = 32'(256 + i);
         cyc();
      end
      dwrite_addr = 14'h14; dwrite_data = 32'h104;
      neg();
      check_b("fill_blocked", dwrite_blocked, 1'b1);
      check_w("fill_head_addr", memaddr, 32'h0000_0040);
      cyc();
      neg();
      check_b("fifth_held", dwrite_blocked, 1'b1);
      cyc();
      ramstate = ACCESS;
      wr_log.delete();
      wr_log_addr.delete();
      neg();
      check_b("blk_in_deq_cycle", dwrite_blocked, 1'b1);
      check_b("deq_wen", memWEN, 1'b1);
      cyc();
      neg();
      check_b("unblk_after_deq", dwrite_blocked, 1'b0);
      cyc();
      dwrite_valid = 1'b0;
      for (int k = 0; k < 40 && wr_log_addr.size() < 5; k++) cyc();
      check_w("drain_count", 32'(wr_log_addr.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < wr_log_addr.size()) begin
            check_w($sformatf("drain_addr%0d", i), wr_log_addr[i], 32'h40 + 32'(4 * i));
            check_w($sformatf("drain_data%0d", i), wr_log[i].data, 32'h100 + 32'(i));
         end
      end
      repeat (2) cyc();
      ramstate = FREE;
      cyc();

      // ---- Wait states on a RAM load of 0x20
      dread_valid = 1'b1; dread_lq = 3'd3; dread_addr = 14'h20; ramstate = BUSY;
      cyc();
      dread_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         neg();
         check_b($sformatf("ws_blocked%0d", i), dread_blocked, 1'b1);
         check_b($sformatf("ws_memREN%0d", i), memREN, 1'b1);
         check_w($sformatf("ws_memaddr%0d", i), memaddr, 32'h0000_0080);
         check_b($sformatf("ws_resp%0d", i), dresp_valid, 1'b0);
         cyc();
      end
      ramstate = ACCESS; ramload = 32'h0000_DEAD;
      neg();
      check_b("ws_blocked_acc", dread_blocked, 1'b1);
      check_b("ws_resp_acc", dresp_valid, 1'b0);
      cyc();
      ramstate = FREE; ramload = '0;
      neg();
      check_b("ws_resp_valid", dresp_valid, 1'b1);
      check_w("ws_resp_lq", 32'(dresp_lq), 32'd3);
      check_w("ws_resp_data", dresp_data, 32'h0000_DEAD);
      check_b("ws_unblocked", dread_blocked, 1'b0);
      cyc();
      neg();
      check_b("ws_pulse", dresp_valid, 1'b0);
      cyc();

      // ---- Priority: load miss, buffered store and i$ request together
      dread_valid = 1'b1; dread_lq = 3'd2; dread_addr = 14'h31; ramstate = BUSY;
      cyc();
      dread_valid = 1'b0; dwrite_valid = 1'b1; dwrite_addr = 14'h40; dwrite_data = 32'h77;
      cyc();
      dwrite_valid = 1'b0; ramstate = ERROR; ramload = 32'h5555;
      neg();
      check_w("pri_setup_addr", memaddr, 32'h0000_00C4);
      cyc();
      dread_valid = 1'b1; dread_lq = 3'd4; dread_addr = 14'h33;
      icache_REN = 1'b1; icache_addr = 32'h0000_0200; ramstate = ACCESS; ramload = 32'h1234;
      neg();
      check_w("err_ld_data", dresp_data, 32'h5555);
      check_w("err_ld_lq", 32'(dresp_lq), 32'd2);
      check_b("pri_idle_hit", icache_hit, 1'b0);
      cyc();
      dread_valid = 1'b0;
      neg();
      check_b("pri1_dread", memREN, 1'b1);
      check_w("pri1_addr", memaddr, 32'h0000_00CC);
      check_b("pri1_hit", icache_hit, 1'b0);
      cyc();
      neg();
      check_w("pri2_resp", dresp_data, 32'h1234);
      check_b("pri2_hit", icache_hit, 1'b0);
      cyc();
      neg();
      check_b("pri3_write", memWEN, 1'b1);
      check_w("pri3_addr", memaddr, 32'h0000_0100);
      check_w("pri3_data", memstore, 32'h77);
      check_b("pri3_hit", icache_hit, 1'b0);
      cyc();
      neg();
      check_b("pri4_hit", icache_hit, 1'b0);
      cyc();
      neg();
      check_b("pri5_iread", memREN, 1'b1);
      check_w("pri5_addr", memaddr, 32'h0000_0200);
      check_b("pri5_hit", icache_hit, 1'b1);
      check_w("pri5_load", icache_load, 32'h1234);
      cyc();
      icache_REN = 1'b0;
      neg();
      check_b("pri6_hit", icache_hit, 1'b0);
      cyc();

      // ---- Halt only after the posted stores have drained
      ramstate = BUSY;
      dwrite_valid = 1'b1; dwrite_addr = 14'h50; dwrite_data = 32'h500;
      cyc();
      dwrite_addr = 14'h51; dwrite_data = 32'h501; halt_in = 1'b1;
      neg();
      check_b("halt_c1", halt_out, 1'b0);
      cyc();
      dwrite_valid = 1'b0;
      neg();
      check_b("halt_c2", halt_out, 1'b0);
      cyc();
      neg();
      check_b("halt_c3", halt_out, 1'b0);
      cyc();
      ramstate = ACCESS;
      neg();
      check_b("halt_c4", halt_out, 1'b0);
      check_w("halt_w1_addr", memaddr, 32'h0000_0140);
      cyc();
      neg();
      check_b("halt_c5", halt_out, 1'b0);
      cyc();
      neg();
      check_b("halt_c6", halt_out, 1'b0);
      check_w("halt_w2_addr", memaddr, 32'h0000_0144);
      cyc();
      neg();
      check_b("halt_c7", halt_out, 1'b1);
      cyc();
      halt_in = 1'b0; ramstate = FREE;
      neg();
      check_b("halt_c8", halt_out, 1'b0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_wb.md
# mem_arbiter_wb

Parametrised single-port memory arbiter with a configurable-depth posted write buffer between one core's i$/d$ request ports and the RAM. It replaces the zero-latency, instant-service hack at the core/RAM seam. It honours RAM wait states via `ramstate` and forwards the youngest buffered store to loads. It also reports a drained halt once all posted writes have reached RAM.

## Interface
Parameters:
- `WB_DEPTH`, 4: write-buffer entries; power of 2, ≥2.
- `ADDR_W`, 14: word-address width of d$ requests.
- `LQ_W`, 3: load-queue index width.

Ports:
- `CLK`  in  1: clock.
- `nRST`  in  1: reset, asynchronous, active-low.
- `icache_REN`  in  1: i$ read request.
- `icache_addr`  in  32: i$ byte address.
- `icache_hit`  out  1: i$ data valid this cycle.
- `icache_load`  out  32: i$ data; equals `ramload`.
- `dread_valid`  in  1: d$ load request.
- `dread_lq`  in  LQ_W: load-queue tag.
- `dread_addr`  in  ADDR_W: word address.
- `dread_blocked`  out  1: load not accepted this cycle.
- `dresp_valid`  out  1: load response.
- `dresp_lq`  out  LQ_W: tag of the response.
- `dresp_data`  out  32: response data.
- `dwrite_valid`  in  1: store request.
- `dwrite_addr`  in  ADDR_W: word address.
- `dwrite_data`  in  32: store data.
- `dwrite_blocked`  out  1: store not accepted (buffer full).
- `memaddr`  out  32: RAM byte address, formed as zero-extended {addr, 2'b00}.
- `memREN`  out  1: RAM read.
- `memWEN`  out  1: RAM write.
- `memstore`  out  32: RAM write data.
- `ramstate`  in  ramstate_t: FREE/BUSY/ACCESS/ERROR.
- `ramload`  in  32: RAM read data.
- `halt_in`  in  1: core halted.
- `halt_out`  out  1: halted and fully drained.

## Operation
- Write buffer: circular FIFO with head/tail pointers of width log2(WB_DEPTH)+1.
  - Empty when pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Store accepted when `dwrite_valid & ~dwrite_blocked`. It enqueues at the tail.
- `dwrite_blocked` = registered full. A dequeue in the same cycle does not unblock.
- FSM states: IDLE, DREAD, WRITE, IREAD. All decisions are made in IDLE, with this priority:
  1. **Load.**
     - Forward hit: respond from the buffer without using RAM; stay IDLE.
     - Miss: capture tag and address, go to DREAD.
  2. **Head entry valid:** go to WRITE.
  3. **`icache_REN`:** go to IREAD.
- Forwarding: CAM over all valid entries plus the store enqueuing in the same cycle. The youngest match wins; the same-cycle store is youngest.
- DREAD/WRITE/IREAD drive `memaddr` and `memREN`/`memWEN` continuously. `memstore` = head data.
- The state holds while `ramstate` is BUSY or FREE. On ACCESS:
  - DREAD: latch `ramload`.
  - WRITE: dequeue the head.
  - IREAD: `icache_hit`=1.
  - All three return to IDLE.
- `ramstate`=ERROR is treated as ACCESS, with the data taken as-is. There is no retry.
- `dread_blocked` = (state ≠ IDLE). A load in IDLE is always accepted.
- `halt_out` = `halt_in` & buffer empty & state IDLE.

## Timing
- Reset values:
  - State IDLE; pointers 0; all entries invalid.
  - All outputs 0: `icache_hit`, `dresp_valid`, `dresp_lq`, `dresp_data`, `memREN`, `memWEN`, `memaddr`, `dwrite_blocked`, `halt_out`.
  - `dread_blocked`=0.
- Forward-hit load: `dresp_valid` is asserted the cycle after acceptance.
- RAM load: `dresp_valid` is asserted the cycle after the ACCESS cycle. Minimum latency is 2 cycles when ACCESS comes on the first DREAD cycle.
- `dresp_valid` is a single-cycle pulse.
- `icache_hit` is combinational in the ACCESS cycle of IREAD only.
- A store enqueued at cycle t is eligible for WRITE selection at t+1.
- Simultaneous enqueue and dequeue: the count is unchanged.
- Pointers wrap modulo 2·WB_DEPTH.
- nRST asserted mid-transaction: the FSM returns to IDLE and buffered stores are discarded. The RAM request drops asynchronously.

## Test plan
- **Reset:** nRST low for 2 cycles during IREAD with `ramstate`=BUSY -> all outputs 0; state IDLE after release.
- **Forwarding:**
  - Stores to 0x10 of 0xA, then 0xB, then a load of 0x10 with tag 5 -> next cycle `dresp_valid`=1, `dresp_lq`=5, `dresp_data`=0xB, and `memREN` stays 0.
  - Repeat with the store to 0x10 of 0xC in the same cycle as the load -> 0xC.
- **Fill and drain:**
  - 4 stores with RAM held BUSY -> `dwrite_blocked`=1 after the 4th; a 5th store is held.
  - Release RAM (ACCESS each cycle) -> writes reach `memaddr` 0x0000_0040.. in FIFO order; blocked drops the cycle after the first dequeue.
- **Wait states:** load of 0x20 with `ramstate` BUSY for 3 cycles then ACCESS with `ramload`=0xDEAD -> `dresp_data`=0xDEAD one cycle after ACCESS; `dread_blocked`=1 throughout.
- **Priority:** `icache_REN`, a valid head entry and `dread_valid` (miss) all in IDLE -> service order is DREAD, WRITE, IREAD; `icache_hit` only on the IREAD ACCESS cycle.
- **Halt:** `halt_in`=1 with 2 buffered stores -> `halt_out`=0 until the second WRITE completes, then 1.
